// File: rtl/pc_fetch_unit.sv
// IF-stage PC owner: resolves Jump_sel redirects, drives the sync imem address and squashes wrong-path fetches.
// Optional feature macro: BRANCH_DELAY_SLOT_EN keeps the fetch issued in a redirect cycle (delay slot).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       Jump_sel,
    input  logic [31:0]      x_pc_plus4,
    input  logic [31:0]      x_imm_sext,
    input  logic [25:0]      x_target,
    input  logic [31:0]      x_rs_val,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_pc_plus4,
    output logic             instr_valid,
    output logic             flush,
    output logic             jr_misalign,
    output logic [CNT_W-1:0] redirect_cnt
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic KEEP_SLOT = 1'b1;
`else
    localparam logic KEEP_SLOT = 1'b0;
`endif

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        fetch_valid_s;
    logic        unused_s;

    assign pc_plus4_s = pc_r + 32'd4;
    // The two top offset bits fall off when the word offset is shifted into bytes.
    assign unused_s   = ^x_imm_sext[31:30];

    // Redirect target selection from the resolved jump kind.
    always_comb begin
        target_s = pc_plus4_s;
        case (Jump_sel)
            2'b01:   target_s = x_pc_plus4 + {x_imm_sext[29:0], 2'b00};
            2'b10:   target_s = {x_pc_plus4[31:28], x_target, 2'b00};
            2'b11:   target_s = {x_rs_val[31:2], 2'b00};
            default: target_s = pc_plus4_s;
        endcase
    end

    // Next-state, next-PC and fetch-validity decode.
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        redirect_s    = 1'b0;
        fetch_valid_s = 1'b0;
        case (state_r)
            BOOT: begin
                if (!stall) begin
                    state_next_s = RUN;
                    pc_next_s    = pc_plus4_s;
                end else begin
                    state_next_s = BOOT;
                    pc_next_s    = pc_r;
                end
            end
            RUN: begin
                state_next_s = RUN;
                if (stall) begin
                    pc_next_s = pc_r;
                end else if (Jump_sel != 2'b00) begin
                    redirect_s    = 1'b1;
                    pc_next_s     = target_s;
                    fetch_valid_s = KEEP_SLOT;
                end else begin
                    pc_next_s     = pc_plus4_s;
                    fetch_valid_s = 1'b1;
                end
            end
            default: begin
                state_next_s = BOOT;
                pc_next_s    = RESET_PC;
            end
        endcase
    end

    // PC, FSM and fetch-return state; a stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= BOOT;
            pc_r         <= RESET_PC;
            instr_valid  <= 1'b0;
            if_pc_plus4  <= 32'd0;
            redirect_cnt <= {CNT_W{1'b0}};
        end else if (!stall) begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            instr_valid <= fetch_valid_s;
            if_pc_plus4 <= pc_plus4_s;
            if (redirect_s) begin
                redirect_cnt <= redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign imem_addr   = pc_r;
    assign flush       = redirect_s;
    assign jr_misalign = redirect_s && (Jump_sel == 2'b11) && (x_rs_val[1:0] != 2'b00);

endmodule
